unified_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between two requesters: the pipeline fetch stage (instruction port) and the memory stage (data port).
- Sits between the arm core and the memory model.
- Arbitrates between the two ports, runs a req/ack transaction with a variable-latency memory, and returns data through registered outputs.
- Drives stall indications that the hazard unit ORs into StallF and into the memory-stage stall.

---
 rtl/unified_mem_arbiter_if.sv | 32 +++
 rtl/unified_mem_arbiter.sv | 87 ++++++++
 tb/tb_unified_mem_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, data and memory buses of the shared-memory arbiter
interface unified_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ready;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ready;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  logic                  stall_f;
  logic                  stall_m;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch and data ports with starvation guard
module unified_mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  unified_mem_arbiter_if.slave     bus
);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t                state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  d_win;
  // a waiting fetch overrides data only once data has won STARVE_LIMIT times in a row
  assign d_win = bus.d_req && !(bus.if_req && starve_cnt_q == LIM);
  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE:
        if (d_win) begin
          state_d      = BUSY_D;
          mem_we_d     = bus.d_we;
          mem_addr_d   = bus.d_addr;
          mem_wdata_d  = bus.d_wdata;
          starve_cnt_d = !bus.if_req ? 4'd0 : starve_cnt_q == LIM ? LIM : starve_cnt_q + 4'd1;
        end else if (bus.if_req) begin
          state_d      = BUSY_I;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          starve_cnt_d = 4'd0;
        end
      BUSY_I:
        if (bus.mem_ack) begin
          state_d    = DONE_I;
          if_rdata_d = bus.mem_rdata;
        end
      BUSY_D:
        if (bus.mem_ack) begin
          state_d   = DONE_D;
          d_rdata_d = mem_we_q ? d_rdata_q : bus.mem_rdata;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
  assign bus.mem_req   = state_q == BUSY_I || state_q == BUSY_D;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ready  = state_q == DONE_I;
  assign bus.d_ready   = state_q == DONE_D;
  assign bus.stall_f   = bus.if_req && state_q != DONE_I;
  assign bus.stall_m   = bus.d_req && state_q != DONE_D;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: randomized and directed checks of the arbiter against a transaction-level model
module tb_unified_mem_arbiter;
  localparam int LIM = 4;
  logic clk;
  logic reset;
  unified_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  unified_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(LIM)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  int passed = 0;
  int total  = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    else passed++;
  endtask
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  // memory responder: ack after lat cycles of mem_req, random read data every cycle
  int          lat_fix = 1;
  bit          fix_rd  = 0;
  logic [31:0] rd_val  = 0;
  bit          force_ack = 0;
  int          mcnt = 0;
  int          mlat = 1;
  initial begin
    bus.mem_ack   = 0;
    bus.mem_rdata = 0;
  end
  always @(negedge clk) begin
    #3;
    if (reset) begin
      bus.mem_ack = 0;
      mcnt = 0;
    end else if (bus.mem_req && !bus.mem_ack) begin
      if (mcnt == 0) mlat = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 8));
      mcnt++;
      if (mcnt >= mlat) begin
        bus.mem_ack = 1;
        mcnt = 0;
      end
    end else bus.mem_ack = force_ack;
    bus.mem_rdata = fix_rd ? rd_val : $urandom;
  end
  // transaction-level model: one owner in flight, a ready pulse after its ack, one idle cycle, then arbitration
  bit          m_act, m_own, m_we;
  logic [1:0]  m_rdy;
  logic [31:0] m_addr, m_wdata, m_ir, m_dr;
  int          m_starve;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act <= 0; m_own <= 0; m_we <= 0; m_rdy <= 0;
      m_addr <= 0; m_wdata <= 0; m_ir <= 0; m_dr <= 0; m_starve <= 0;
    end else if (m_act) begin
      if (bus.mem_ack) begin
        m_act <= 0;
        m_rdy <= m_own ? 2'd2 : 2'd1;
        if (!m_own) m_ir <= bus.mem_rdata;
        else if (!m_we) m_dr <= bus.mem_rdata;
      end
    end else if (m_rdy != 0) m_rdy <= 0;
    else if (bus.d_req && !(bus.if_req && m_starve == LIM)) begin
      m_act <= 1; m_own <= 1; m_we <= bus.d_we; m_addr <= bus.d_addr; m_wdata <= bus.d_wdata;
      m_starve <= bus.if_req ? (m_starve < LIM ? m_starve + 1 : LIM) : 0;
    end else if (bus.if_req) begin
      m_act <= 1; m_own <= 0; m_we <= 0; m_addr <= bus.if_addr; m_starve <= 0;
    end
  end
  always @(negedge clk) begin
    chk("mem_req", bus.mem_req, m_act);
    chk("mem_we", bus.mem_we, m_we);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("if_ready", bus.if_ready, m_rdy == 1);
    chk("d_ready", bus.d_ready, m_rdy == 2);
    chk("if_rdata", bus.if_rdata, m_ir);
    chk("d_rdata", bus.d_rdata, m_dr);
    chk("stall_f", bus.stall_f, bus.if_req && m_rdy != 1);
    chk("stall_m", bus.stall_m, bus.d_req && m_rdy != 2);
    chk("ready_excl", bus.if_ready && bus.d_ready, 0);
  end
  // grant log seen on the memory bus: 1 = fetch (address 0x100), 0 = data
  bit glog[$];
  bit prev_req = 0;
  always @(negedge clk) begin
    if (bus.mem_req && !prev_req) glog.push_back(bus.mem_addr == 32'h100);
    prev_req = bus.mem_req;
  end
  task automatic txn(input bit isd, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input int l, input int exp_lat, input string n);
    int c;
    @(negedge clk);
    #2;
    lat_fix = l;
    if (isd) begin
      bus.d_req = 1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1; bus.if_addr = a;
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(isd ? bus.d_ready : bus.if_ready) && c < 40);
    chk(n, c, exp_lat);
    #2;
    bus.d_req = 0;
    bus.if_req = 0;
  endtask
  int n_is, n_ds, n_ir, n_dr, dr_at, ir_at, g0;
  bit d_done;
  logic [6:0] pat;
  initial begin
    reset = 1;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    #2 reset = 0;
    fix_rd = 1; rd_val = 32'hE3A0_0005;
    txn(0, 0, 32'h10, 0, 1, 2, "fetch_lat");
    chk("fetch_rdata", bus.if_rdata, 32'hE3A0_0005);
    chk("fetch_addr", bus.mem_addr, 32'h10);
    chk("fetch_we", bus.mem_we, 0);
    fix_rd = 0;
    txn(1, 1, 32'h64, 32'hDEAD_BEEF, 3, 4, "store_lat");
    chk("store_we", bus.mem_we, 1);
    chk("store_addr", bus.mem_addr, 32'h64);
    chk("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("store_d_rdata", bus.d_rdata, 0);
    @(negedge clk);
    #2;
    lat_fix = 1;
    bus.if_req = 1; bus.if_addr = 32'h20;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h30;
    dr_at = 0; ir_at = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.d_ready) dr_at = c;
      if (bus.if_ready) ir_at = c;
      if (c < 5) chk("contend_stall_f", bus.stall_f, 1);
      #2;
      if (bus.d_ready) bus.d_req = 0;
      if (bus.if_ready) begin
        bus.if_req = 0;
        break;
      end
    end
    chk("contend_d_at", dr_at, 2);
    chk("contend_i_at", ir_at, 5);
    @(negedge clk);
    #2;
    g0 = glog.size();
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    d_done = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      #2;
      if (!d_done && glog.size() - g0 >= 6 && bus.d_ready) begin
        bus.d_req = 0;
        d_done = 1;
      end else if (d_done && bus.if_ready) begin
        bus.if_req = 0;
        break;
      end
    end
    for (int i = 0; i < 7; i++) pat[i] = (g0 + i < glog.size()) ? glog[g0 + i] : 1'b0;
    chk("starve_count", glog.size() - g0, 7);
    chk("starve_order", pat, 7'b101_0000);
    bus.if_req = 0; bus.d_req = 0;
    @(negedge clk);
    #2;
    lat_fix = 100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h44;
    @(negedge clk);
    chk("rstmid_busy", bus.mem_req, 1);
    chk("rstmid_addr", bus.mem_addr, 32'h44);
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rstmid_mem_req", bus.mem_req, 0);
    chk("rstmid_d_ready", bus.d_ready, 0);
    chk("rstmid_mem_addr", bus.mem_addr, 0);
    chk("rstmid_if_rdata", bus.if_rdata, 0);
    chk("rstmid_d_rdata", bus.d_rdata, 0);
    @(negedge clk);
    #2;
    reset = 0; bus.d_req = 0; force_ack = 1; lat_fix = 1;
    @(negedge clk);
    #2 force_ack = 0;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_req", bus.mem_req, 0);
      chk("late_ack_ready", bus.d_ready, 0);
    end
    for (int l = 1; l <= 8; l++) begin
      txn(0, 0, 32'h1000 + 32'(l * 4), 0, l, l + 1, "sweep_i_lat");
      txn(1, 0, 32'h2000 + 32'(l * 4), 0, l, l + 1, "sweep_d_lat");
    end
    lat_fix = 0;
    n_is = 0; n_ds = 0; n_ir = 0; n_dr = 0;
    for (int c = 0; c < 4300; c++) begin
      @(negedge clk);
      if (bus.if_ready) n_ir++;
      if (bus.d_ready) n_dr++;
      if (c >= 4000 && !bus.if_req && !bus.d_req) break;
      #2;
      if (bus.if_req && bus.if_ready) bus.if_req = 0;
      else if (!bus.if_req && c < 4000 && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1; bus.if_addr = $urandom & 32'hFFFF_FFFC; n_is++;
      end
      if (bus.d_req && bus.d_ready) bus.d_req = 0;
      else if (!bus.d_req && c < 4000 && $urandom_range(0, 2) == 0) begin
        bus.d_req = 1; bus.d_we = 1'($urandom); bus.d_addr = $urandom & 32'hFFFF_FFFC;
        bus.d_wdata = $urandom; n_ds++;
      end
    end
    chk("rand_drained", bus.if_req || bus.d_req, 0);
    chk("rand_if_pulses", n_ir, n_is);
    chk("rand_d_pulses", n_dr, n_ds);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
